// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-framed, bit-serial augmented CRC generator with a valid/ready result handshake
module crc_frame_ctrl #(
   parameter int                  CRC_LEN        = 16,
   parameter logic [CRC_LEN-1:0]  CRC_POLYNOMIAL = 16'h8005
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [CRC_LEN-1:0] crc_out,
   output logic               crc_valid,
   input  logic               crc_ready,
   output logic               busy
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam int CW = $clog2((CRC_LEN > 8 ? CRC_LEN : 8) + 1);
   logic [2:0]         state_q, state_d;
   logic [CRC_LEN-1:0] crc_q, crc_d, step;
   logic [7:0]         byte_q, byte_d;
   logic               last_q, last_d, next_bit;
   logic [CW-1:0]      cnt_q, cnt_d;
   assign in_ready  = (state_q == IDLE) || (state_q == WAIT);
   assign crc_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign crc_out   = crc_q;
   // Flush phase feeds zeros, which appends CRC_LEN zero bits to the message
   assign next_bit  = (state_q == SHIFT) ? byte_q[7] : 1'b0;
   assign step      = {crc_q[CRC_LEN-2:0], next_bit} ^ (CRC_POLYNOMIAL & {CRC_LEN{crc_q[CRC_LEN-1]}});
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      byte_d  = byte_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, WAIT: if (in_valid) begin
            crc_d   = (state_q == IDLE) ? '0 : crc_q;
            byte_d  = in_data;
            last_d  = in_last;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            crc_d   = step;
            byte_d  = {byte_q[6:0], 1'b0};
            cnt_d   = (cnt_q == CW'(7)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q != CW'(7)) ? SHIFT : last_q ? FLUSH : WAIT;
         end
         FLUSH: begin
            crc_d   = step;
            cnt_d   = (cnt_q == CW'(CRC_LEN - 1)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == CW'(CRC_LEN - 1)) ? DONE : FLUSH;
         end
         DONE: state_d = crc_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         crc_q   <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
